// File: rtl/bit_rev_scrambler_pkg.sv
// bit_rev_scrambler_pkg: shared FFT sizing, scrambler state enum and bit-reversal helper
package bit_rev_scrambler_pkg;
  localparam int DW    = 56;
  localparam int N     = 256;
  localparam int LOG2N = 8;
  localparam int LANES = 8;
  localparam int LW    = $clog2(LANES);
  localparam int GW    = LOG2N - LW;
  typedef enum logic {LOAD, DRAIN} scr_state_e;
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction
endpackage

// File: rtl/bit_rev_scrambler.sv
// bit_rev_scrambler: loads a 256-sample frame in natural order, drains it 8 lanes per beat in bit-reversed order
//   in_valid/in_data/in_ready     : one sample per accepted cycle while loading
//   out_valid/out_ready/scr_out0-7: one beat of 8 bit-reversed samples while draining
//   out_grp                       : beat index within the frame
//   done                          : one-cycle pulse after the last beat is consumed
module bit_rev_scrambler
  import bit_rev_scrambler_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] scr_out0,
  output logic [DW-1:0] scr_out1,
  output logic [DW-1:0] scr_out2,
  output logic [DW-1:0] scr_out3,
  output logic [DW-1:0] scr_out4,
  output logic [DW-1:0] scr_out5,
  output logic [DW-1:0] scr_out6,
  output logic [DW-1:0] scr_out7,
  output logic [GW-1:0] out_grp,
  output logic          done
);
  scr_state_e       state_q, state_d;
  logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
  logic [GW-1:0]    rd_grp_q, rd_grp_d;
  logic             done_q, done_d;
  logic             wr_en, rd_en, last_wr, last_rd;
  logic [DW-1:0]    mem_q [N];
  logic [DW-1:0]    lane [LANES];

  always_comb begin
    wr_en    = in_valid && state_q == LOAD;
    rd_en    = out_ready && state_q == DRAIN;
    last_wr  = wr_en && &wr_cnt_q;
    last_rd  = rd_en && &rd_grp_q;
    wr_cnt_d = wr_en ? wr_cnt_q + 1'b1 : wr_cnt_q;
    rd_grp_d = last_wr ? '0 : rd_en ? rd_grp_q + 1'b1 : rd_grp_q;
    state_d  = last_wr ? DRAIN : last_rd ? LOAD : state_q;
    done_d   = last_rd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LOAD;
      wr_cnt_q <= '0;
      rd_grp_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_grp_q <= rd_grp_d;
      done_q   <= done_d;
    end
  end

  // no reset on storage: DRAIN is only reachable after a full reload
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_cnt_q] <= in_data;
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane[k] = mem_q[bitrev({rd_grp_q, LW'(k)})];
  end

  assign in_ready  = state_q == LOAD;
  assign out_valid = state_q == DRAIN;
  assign out_grp   = rd_grp_q;
  assign done      = done_q;
  assign scr_out0  = lane[0];
  assign scr_out1  = lane[1];
  assign scr_out2  = lane[2];
  assign scr_out3  = lane[3];
  assign scr_out4  = lane[4];
  assign scr_out5  = lane[5];
  assign scr_out6  = lane[6];
  assign scr_out7  = lane[7];
endmodule
